// File: rtl/mdu_issue_ctrl_pkg.sv
// Shared ALU-code definitions for the M-extension issue path: opcode constants,
// issue-controller state encoding and the mul/div opcode classifier.
package mdu_issue_ctrl_pkg;
  localparam int ALU_W  = 6;
  localparam int DATA_W = 32;

  localparam logic [ALU_W-1:0] ALU_MUL    = 6'h20;
  localparam logic [ALU_W-1:0] ALU_MULH   = 6'h21;
  localparam logic [ALU_W-1:0] ALU_MULHSU = 6'h22;
  localparam logic [ALU_W-1:0] ALU_MULHU  = 6'h23;
  localparam logic [ALU_W-1:0] ALU_DIV    = 6'h24;
  localparam logic [ALU_W-1:0] ALU_DIVU   = 6'h25;
  localparam logic [ALU_W-1:0] ALU_REM    = 6'h26;
  localparam logic [ALU_W-1:0] ALU_REMU   = 6'h27;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WB    = 2'd3
  } mdu_state_e;

  // All eight M-extension codes share the 3'b100 prefix.
  function automatic logic is_muldiv(input logic [ALU_W-1:0] code);
    return (code[ALU_W-1:3] == 3'b100);
  endfunction
endpackage

// File: rtl/mdu_result_cache.sv
// Single-entry memo of the last completed mul/div: a lookup hits when the
// opcode and both operands match the stored entry.
module mdu_result_cache
  import mdu_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              invalidate,
  input  logic [ALU_W-1:0]  lookup_alucode,
  input  logic [DATA_W-1:0] lookup_op1,
  input  logic [DATA_W-1:0] lookup_op2,
  output logic              hit,
  output logic [DATA_W-1:0] hit_data,
  input  logic              update,
  input  logic [ALU_W-1:0]  upd_alucode,
  input  logic [DATA_W-1:0] upd_op1,
  input  logic [DATA_W-1:0] upd_op2,
  input  logic [DATA_W-1:0] upd_data
);
  logic              entry_vld;
  logic [ALU_W-1:0]  entry_alucode;
  logic [DATA_W-1:0] entry_op1;
  logic [DATA_W-1:0] entry_op2;
  logic [DATA_W-1:0] entry_data;

  always_ff @(posedge clk) begin
    if (invalidate)  entry_vld <= 1'b0;
    else if (update) entry_vld <= 1'b1;
  end

  // Entry payload carries no reset; entry_vld alone qualifies it.
  always_ff @(posedge clk) begin
    if (update) begin
      entry_alucode <= upd_alucode;
      entry_op1     <= upd_op1;
      entry_op2     <= upd_op2;
      entry_data    <= upd_data;
    end
  end

  assign hit = entry_vld && (entry_alucode == lookup_alucode) &&
               (entry_op1 == lookup_op1) && (entry_op2 == lookup_op2);
  assign hit_data = entry_data;
endmodule

// File: rtl/mdu_issue_ctrl.sv
// Issue controller between the execute stage and the multi-cycle mul/div unit:
// accepts an op, serves repeats from a one-entry result cache, otherwise starts
// the unit and waits for completion before a one-cycle writeback.
module mdu_issue_ctrl
  import mdu_issue_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_in,
  input  logic [ALU_W-1:0]  alucode,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  input  logic [4:0]        rd,
  input  logic              flush,
  output logic              stall,
  output logic              mcu_start,
  output logic [ALU_W-1:0]  mcu_alucode,
  output logic [DATA_W-1:0] mcu_op1,
  output logic [DATA_W-1:0] mcu_op2,
  input  logic [DATA_W-1:0] mcu_result,
  input  logic              mcu_done,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
);
  mdu_state_e        state, state_n;
  logic              wait_first;
  logic [4:0]        rd_q;
  logic              accept;
  logic              issue;
  logic              hit;
  logic [DATA_W-1:0] hit_data;
  logic              cache_upd;

  assign accept    = (state == ST_IDLE) && valid_in && !flush && is_muldiv(alucode);
  assign issue     = accept && (rd != 5'd0);
  // done is only trusted once the start pulse and one WAIT cycle have passed.
  assign cache_upd = (state == ST_WAIT) && !wait_first && mcu_done && !flush;
  assign stall     = (state != ST_IDLE);

  mdu_result_cache u_cache (
    .clk            (clk),
    .invalidate     (rst),
    .lookup_alucode (alucode),
    .lookup_op1     (op1),
    .lookup_op2     (op2),
    .hit            (hit),
    .hit_data       (hit_data),
    .update         (cache_upd),
    .upd_alucode    (mcu_alucode),
    .upd_op1        (mcu_op1),
    .upd_op2        (mcu_op2),
    .upd_data       (mcu_result)
  );

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (issue) state_n = hit ? ST_WB : ST_START;
      ST_START: state_n = flush ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (flush)          state_n = ST_IDLE;
        else if (cache_upd) state_n = ST_WB;
      end
      ST_WB:    state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      wait_first  <= 1'b0;
      mcu_start   <= 1'b0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      mcu_alucode <= '0;
      mcu_op1     <= '0;
      mcu_op2     <= '0;
    end else begin
      state      <= state_n;
      wait_first <= (state == ST_START);
      mcu_start  <= (state_n == ST_START);
      wb_valid   <= (state_n == ST_WB);
      if (state_n == ST_WB) begin
        wb_rd   <= (state == ST_IDLE) ? rd : rd_q;
        wb_data <= (state == ST_IDLE) ? hit_data : mcu_result;
      end else begin
        wb_rd   <= '0;
        wb_data <= '0;
      end
      if (issue && !hit) begin
        mcu_alucode <= alucode;
        mcu_op1     <= op1;
        mcu_op2     <= op2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) rd_q <= rd;
  end
endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Directed bench for mdu_issue_ctrl; the bench plays the mul/div unit and
// supplies hand-computed results and done timing.
module tb_mdu_issue_ctrl;
  import mdu_issue_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [5:0]  alucode;
  logic [31:0] op1, op2;
  logic [4:0]  rd;
  logic        flush;
  logic        stall;
  logic        mcu_start;
  logic [5:0]  mcu_alucode;
  logic [31:0] mcu_op1, mcu_op2;
  logic [31:0] mcu_result;
  logic        mcu_done;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks   = 0;
  int failures = 0;

  mdu_issue_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .valid_in    (valid_in),
    .alucode     (alucode),
    .op1         (op1),
    .op2         (op2),
    .rd          (rd),
    .flush       (flush),
    .stall       (stall),
    .mcu_start   (mcu_start),
    .mcu_alucode (mcu_alucode),
    .mcu_op1     (mcu_op1),
    .mcu_op2     (mcu_op2),
    .mcu_result  (mcu_result),
    .mcu_done    (mcu_done),
    .wb_valid    (wb_valid),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Miss path: START at T+1, first WAIT at T+2, real done presented from T+3+extra.
  task automatic run_miss(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] r, input logic [31:0] res, input int extra,
                          input bit stale);
    valid_in = 1'b1; alucode = code; op1 = a; op2 = b; rd = r;
    check_eq("idle_stall", {31'd0, stall}, 32'd0);
    if (stale) begin mcu_done = 1'b1; mcu_result = 32'hDEAD_BEEF; end
    tick();
    valid_in = 1'b0;
    check_eq("start_pulse", {31'd0, mcu_start}, 32'd1);
    check_eq("start_stall", {31'd0, stall}, 32'd1);
    check_eq("start_no_wb", {31'd0, wb_valid}, 32'd0);
    check_eq("mcu_alucode", {26'd0, mcu_alucode}, {26'd0, code});
    check_eq("mcu_op1", mcu_op1, a);
    check_eq("mcu_op2", mcu_op2, b);
    tick();
    check_eq("wait1_no_start", {31'd0, mcu_start}, 32'd0);
    check_eq("wait1_no_wb", {31'd0, wb_valid}, 32'd0);
    check_eq("wait1_stall", {31'd0, stall}, 32'd1);
    tick();
    check_eq("wait2_no_wb", {31'd0, wb_valid}, 32'd0);
    mcu_done = 1'b0;
    for (int i = 0; i < extra; i++) begin
      tick();
      check_eq("waitn_no_wb", {31'd0, wb_valid}, 32'd0);
      check_eq("waitn_stall", {31'd0, stall}, 32'd1);
    end
    mcu_done = 1'b1; mcu_result = res;
    tick();
    mcu_done = 1'b0;
    check_eq("wb_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("wb_rd", {27'd0, wb_rd}, {27'd0, r});
    check_eq("wb_data", wb_data, res);
    check_eq("wb_stall", {31'd0, stall}, 32'd1);
    check_eq("wb_no_start", {31'd0, mcu_start}, 32'd0);
    tick();
    check_eq("post_wb_valid", {31'd0, wb_valid}, 32'd0);
    check_eq("post_wb_stall", {31'd0, stall}, 32'd0);
  endtask

  task automatic run_hit(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] res);
    valid_in = 1'b1; alucode = code; op1 = a; op2 = b; rd = r;
    tick();
    valid_in = 1'b0;
    check_eq("hit_wb_valid", {31'd0, wb_valid}, 32'd1);
    check_eq("hit_wb_rd", {27'd0, wb_rd}, {27'd0, r});
    check_eq("hit_wb_data", wb_data, res);
    check_eq("hit_no_start", {31'd0, mcu_start}, 32'd0);
    check_eq("hit_stall", {31'd0, stall}, 32'd1);
    tick();
    check_eq("hit_post_wb", {31'd0, wb_valid}, 32'd0);
    check_eq("hit_post_start", {31'd0, mcu_start}, 32'd0);
    check_eq("hit_post_stall", {31'd0, stall}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check_eq({tag, "_start"}, {31'd0, mcu_start}, 32'd0);
    check_eq({tag, "_wb_valid"}, {31'd0, wb_valid}, 32'd0);
    check_eq({tag, "_wb_rd"}, {27'd0, wb_rd}, 32'd0);
    check_eq({tag, "_wb_data"}, wb_data, 32'd0);
    check_eq({tag, "_mcu_alucode"}, {26'd0, mcu_alucode}, 32'd0);
    check_eq({tag, "_mcu_op1"}, mcu_op1, 32'd0);
    check_eq({tag, "_mcu_op2"}, mcu_op2, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; valid_in = 1'b0; alucode = '0; op1 = '0; op2 = '0; rd = '0;
    flush = 1'b0; mcu_result = '0; mcu_done = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    run_miss(ALU_MUL, 32'd3, 32'd4, 5'd5, 32'h0000_000C, 0, 1'b0);
    run_miss(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFD, 1, 1'b0);
    run_miss(ALU_REM, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'hFFFF_FFFF, 0, 1'b0);
    run_miss(ALU_DIVU, 32'h10, 32'd0, 5'd8, 32'hFFFF_FFFF, 3, 1'b0);
    run_hit(ALU_DIVU, 32'h10, 32'd0, 5'd9, 32'hFFFF_FFFF);

    // Stale done held through START and the first WAIT cycle.
    run_miss(ALU_MUL, 32'd5, 32'd6, 5'd10, 32'h0000_001E, 1, 1'b1);

    // Flush during WAIT kills the op; the unit's late done must be ignored.
    valid_in = 1'b1; alucode = ALU_MUL; op1 = 32'd7; op2 = 32'd6; rd = 5'd11;
    tick();
    valid_in = 1'b0;
    check_eq("fl_start", {31'd0, mcu_start}, 32'd1);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("fl_idle_stall", {31'd0, stall}, 32'd0);
    check_eq("fl_no_wb", {31'd0, wb_valid}, 32'd0);
    mcu_done = 1'b1; mcu_result = 32'h0000_002A;
    tick();
    mcu_done = 1'b0;
    check_eq("fl_late_done_wb", {31'd0, wb_valid}, 32'd0);
    check_eq("fl_late_done_stall", {31'd0, stall}, 32'd0);
    run_miss(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFE, 0, 1'b0);
    run_hit(ALU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFE);
    run_miss(ALU_MUL, 32'd7, 32'd6, 5'd14, 32'h0000_002A, 0, 1'b0);

    // flush and valid_in together in IDLE: not accepted.
    valid_in = 1'b1; flush = 1'b1; alucode = ALU_DIV; op1 = 32'd9; op2 = 32'd3; rd = 5'd15;
    tick();
    valid_in = 1'b0; flush = 1'b0;
    check_eq("fv_stall", {31'd0, stall}, 32'd0);
    check_eq("fv_start", {31'd0, mcu_start}, 32'd0);
    check_eq("fv_wb", {31'd0, wb_valid}, 32'd0);

    // rd=0: both a would-be hit and a miss are swallowed.
    valid_in = 1'b1; alucode = ALU_MUL; op1 = 32'd7; op2 = 32'd6; rd = 5'd0;
    tick();
    check_eq("rd0_hit_wb", {31'd0, wb_valid}, 32'd0);
    check_eq("rd0_hit_stall", {31'd0, stall}, 32'd0);
    op1 = 32'd1; op2 = 32'd1;
    tick();
    valid_in = 1'b0;
    check_eq("rd0_miss_start", {31'd0, mcu_start}, 32'd0);
    check_eq("rd0_miss_stall", {31'd0, stall}, 32'd0);
    check_eq("rd0_miss_wb", {31'd0, wb_valid}, 32'd0);

    // rst in WAIT with done high: no writeback, outputs cleared, cache emptied.
    valid_in = 1'b1; alucode = ALU_MUL; op1 = 32'd2; op2 = 32'd2; rd = 5'd16;
    tick();
    valid_in = 1'b0;
    tick(); tick();
    check_eq("rst_pre_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1; mcu_done = 1'b1; mcu_result = 32'd4; flush = 1'b1;
    tick();
    rst = 1'b0; mcu_done = 1'b0; flush = 1'b0;
    check_all_zero("midrst");
    tick();
    check_eq("midrst_no_wb", {31'd0, wb_valid}, 32'd0);
    run_miss(ALU_MUL, 32'd7, 32'd6, 5'd17, 32'h0000_002A, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
